// File: rtl/udp_panel_reader.sv
// Panel RAM readback: streams a run of {addr,r,g,b} pixel words as one UDP packet, MSB byte first.
// One pixel per 4+READ_LATENCY+1 cycles; a stalled byte holds valid/data/meta and no new read is issued.
module udp_panel_reader #(
  parameter logic [7:0]  PORT_MSB     = 8'h66,
  parameter int unsigned MAX_PIXELS   = 256,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_panel,
  input  logic [13:0] req_addr,
  input  logic [15:0] req_count,
  input  logic [31:0] req_ip,
  input  logic [15:0] req_port,
  output logic        busy,
  output logic        done,
  output logic [5:0]  ctrl_rd_en,
  output logic [15:0] ctrl_addr,
  input  logic [23:0] ctrl_rdat,
  output logic        udp_sink_valid,
  input  logic        udp_sink_ready,
  output logic        udp_sink_last,
  output logic [15:0] udp_sink_src_port,
  output logic [15:0] udp_sink_dst_port,
  output logic [31:0] udp_sink_ip_address,
  output logic [15:0] udp_sink_length,
  output logic [31:0] udp_sink_data,
  output logic [3:0]  udp_sink_last_be
);
  localparam logic [15:0] MAX_N    = 16'(MAX_PIXELS);
  localparam logic [2:0]  LAT_LAST = 3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RD, WAIT, SEND} state_t;

  state_t      state_q, state_d;
  logic        started_q;
  logic [5:0]  panel_q;
  logic [13:0] addr_q;
  logic [15:0] n_q;
  logic [31:0] word_q;
  logic [1:0]  byte_q;
  logic [2:0]  lat_q;
  logic        busy_q, done_q;
  logic [15:0] src_q, port_q, len_q;
  logic [31:0] ip_q;

  logic [5:0]  panel_sel;
  logic [15:0] n_req;
  logic        accept, empty_req, beat, pixel_done, pkt_done;
  logic        unused_rdat;

  // Lowest set bit of the panel mask wins; the rest are ignored.
  assign panel_sel  = req_panel & (~req_panel + 6'd1);
  assign n_req      = (req_count > MAX_N) ? MAX_N : req_count;
  assign empty_req  = (n_req == 16'd0) || (req_panel == 6'd0);
  assign pixel_done = beat && (byte_q == 2'd3);
  assign pkt_done   = pixel_done && (n_q == 16'd1);
  assign unused_rdat = ^{ctrl_rdat[23:22], ctrl_rdat[15:14], ctrl_rdat[7:6]};

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    ctrl_rd_en     = 6'd0;
    udp_sink_valid = 1'b0;
    accept         = 1'b0;
    beat           = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = started_q;
        accept    = req_valid && started_q;
        if (accept && !empty_req) state_d = RD;
      end
      RD: begin
        ctrl_rd_en = panel_q;
        state_d    = WAIT;
      end
      WAIT: begin
        if (lat_q == LAT_LAST) state_d = SEND;
      end
      SEND: begin
        udp_sink_valid = 1'b1;
        beat           = udp_sink_ready;
        if (beat && byte_q == 2'd3) state_d = (n_q == 16'd1) ? IDLE : RD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      started_q <= 1'b0;
      panel_q   <= 6'd0;
      addr_q    <= 14'd0;
      n_q       <= 16'd0;
      word_q    <= 32'd0;
      byte_q    <= 2'd0;
      lat_q     <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      src_q     <= 16'd0;
      port_q    <= 16'd0;
      len_q     <= 16'd0;
      ip_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      done_q    <= (accept && empty_req) || pkt_done;
      if (accept) begin
        panel_q <= panel_sel;
        addr_q  <= req_addr;
        n_q     <= n_req;
        ip_q    <= req_ip;
        port_q  <= req_port;
        src_q   <= {PORT_MSB, 2'b00, panel_sel};
        len_q   <= {n_req[13:0], 2'b00};
        busy_q  <= !empty_req;
      end
      if (state_q == RD) lat_q <= 3'd0;
      else if (state_q == WAIT) lat_q <= lat_q + 3'd1;
      if (state_q == WAIT && lat_q == LAT_LAST) begin
        word_q <= {addr_q, ctrl_rdat[21:16], ctrl_rdat[13:8], ctrl_rdat[5:0]};
        byte_q <= 2'd0;
      end
      // Outgoing byte is always word_q[31:24]; shift on each accepted beat.
      if (beat) begin
        byte_q <= byte_q + 2'd1;
        word_q <= {word_q[23:0], 8'h00};
      end
      if (pixel_done) begin
        n_q    <= n_q - 16'd1;
        addr_q <= addr_q + 14'd1;
      end
      if (pkt_done) busy_q <= 1'b0;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign ctrl_addr           = {2'b00, addr_q};
  assign udp_sink_last       = udp_sink_valid && (byte_q == 2'd3) && (n_q == 16'd1);
  assign udp_sink_last_be    = {3'b000, udp_sink_last};
  assign udp_sink_data       = {24'd0, word_q[31:24]};
  assign udp_sink_src_port   = src_q;
  assign udp_sink_dst_port   = port_q;
  assign udp_sink_ip_address = ip_q;
  assign udp_sink_length     = len_q;
endmodule

// File: tb/tb_udp_panel_reader.sv
// Randomized bench for udp_panel_reader with a packet-level reference model and RAM model.
module tb_udp_panel_reader;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_panel = 6'd0;
  logic [13:0] req_addr = 14'd0;
  logic [15:0] req_count = 16'd0;
  logic [31:0] req_ip = 32'd0;
  logic [15:0] req_port = 16'd0;
  logic        busy, done;
  logic [5:0]  ctrl_rd_en;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_rdat = 24'd0;
  logic        udp_sink_valid;
  logic        udp_sink_ready = 1'b1;
  logic        udp_sink_last;
  logic [15:0] udp_sink_src_port, udp_sink_dst_port, udp_sink_length;
  logic [31:0] udp_sink_ip_address, udp_sink_data;
  logic [3:0]  udp_sink_last_be;

  always #5 clock = ~clock;

  udp_panel_reader dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_panel(req_panel),
    .req_addr(req_addr), .req_count(req_count), .req_ip(req_ip), .req_port(req_port),
    .busy(busy), .done(done),
    .ctrl_rd_en(ctrl_rd_en), .ctrl_addr(ctrl_addr), .ctrl_rdat(ctrl_rdat),
    .udp_sink_valid(udp_sink_valid), .udp_sink_ready(udp_sink_ready),
    .udp_sink_last(udp_sink_last), .udp_sink_src_port(udp_sink_src_port),
    .udp_sink_dst_port(udp_sink_dst_port), .udp_sink_ip_address(udp_sink_ip_address),
    .udp_sink_length(udp_sink_length), .udp_sink_data(udp_sink_data),
    .udp_sink_last_be(udp_sink_last_be)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Panel RAM contents; one address carries a fixed known pattern.
  function automatic logic [23:0] ram_val(input logic [5:0] p, input logic [13:0] a);
    logic [31:0] h;
    if (a == 14'h1234) return 24'h3F152A;
    h = (({18'd0, a} * 32'h0000_9E37) + ({26'd0, p} * 32'h0000_79B9)) ^ 32'h005A_C3A5;
    return h[23:0];
  endfunction

  function automatic logic [31:0] pix_word(input logic [5:0] p, input logic [13:0] a);
    logic [23:0] d;
    d = ram_val(p, a);
    return {a, d[21:16], d[13:8], d[5:0]};
  endfunction

  // Registered read port, READ_LATENCY = 1.
  always @(posedge clock) begin
    if (ctrl_rd_en != 6'd0) ctrl_rdat <= ram_val(ctrl_rd_en, ctrl_addr[13:0]);
  end

  bit rnd_ready = 1'b0;
  initial begin
    forever begin
      @(posedge clock);
      #1;
      udp_sink_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  logic [8:0]  bytes[$];
  logic [21:0] rds[$];
  int          done_cnt = 0;
  bit          stalled = 1'b0;
  logic [8:0]  stall_snap;
  logic [15:0] exp_src, exp_len, exp_port;
  logic [31:0] exp_ip;

  always @(negedge clock) begin
    if (!reset_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk_eq("stall_valid", udp_sink_valid, 1);
        chk_eq("stall_data", {udp_sink_last, udp_sink_data[7:0]}, stall_snap);
      end
      if (udp_sink_valid) begin
        chk_eq("src_port", udp_sink_src_port, exp_src);
        chk_eq("dst_port", udp_sink_dst_port, exp_port);
        chk_eq("ip", udp_sink_ip_address, exp_ip);
        chk_eq("length", udp_sink_length, exp_len);
        chk_eq("data_hi", udp_sink_data[31:8], 0);
        chk_eq("last_be", udp_sink_last_be, udp_sink_last ? 4'b0001 : 4'b0000);
        chk_eq("busy_send", busy, 1);
        chk_eq("ready_busy", req_ready, 0);
        if (udp_sink_ready) bytes.push_back({udp_sink_last, udp_sink_data[7:0]});
      end
      stalled    = udp_sink_valid && !udp_sink_ready;
      stall_snap = {udp_sink_last, udp_sink_data[7:0]};
      if (ctrl_rd_en != 6'd0) rds.push_back({ctrl_rd_en, ctrl_addr});
      if (done) done_cnt++;
    end
  end

  task automatic set_expect(input logic [5:0] pm, input logic [15:0] cnt, input logic [31:0] ip,
                            input logic [15:0] port, output logic [5:0] p, output int n);
    p = 6'd0;
    for (int i = 0; i < 6; i++) begin
      if (pm[i]) begin
        p = 6'b1 << i;
        break;
      end
    end
    n = (cnt > 16'd256) ? 256 : int'(cnt);
    if (p == 6'd0) n = 0;
    exp_src  = {8'h66, 2'b00, p};
    exp_len  = 16'(4 * n);
    exp_ip   = ip;
    exp_port = port;
    bytes.delete();
    rds.delete();
    done_cnt = 0;
  endtask

  task automatic issue(input logic [5:0] pm, input logic [13:0] a, input logic [15:0] cnt,
                       input logic [31:0] ip, input logic [15:0] port);
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clock);
      seen = req_ready;
    end
    if (!seen) chk_eq("req_ready_timeout", 0, 1);
    @(posedge clock);
    #1;
    req_valid = 1'b1; req_panel = pm; req_addr = a; req_count = cnt; req_ip = ip; req_port = port;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic run_req(input logic [5:0] pm, input logic [13:0] a, input logic [15:0] cnt,
                         input logic [31:0] ip, input logic [15:0] port);
    logic [5:0]  p;
    int          n;
    logic [31:0] w;
    logic [7:0]  b;
    set_expect(pm, cnt, ip, port, p, n);
    issue(pm, a, cnt, ip, port);
    for (int k = 0; k < 10000 && done_cnt == 0; k++) @(negedge clock);
    repeat (4) @(negedge clock);
    chk_eq("done_count", done_cnt, 1);
    chk_eq("busy_after", busy, 0);
    chk_eq("read_count", rds.size(), n);
    for (int i = 0; i < n && i < rds.size(); i++)
      chk_eq("read_addr", rds[i], {p, 2'b00, 14'((int'(a) + i) % 16384)});
    chk_eq("byte_count", bytes.size(), 4 * n);
    for (int j = 0; j < 4 * n && j < bytes.size(); j++) begin
      w = pix_word(p, 14'((int'(a) + j / 4) % 16384));
      b = 8'(w >> (8 * (3 - (j % 4))));
      chk_eq("payload", bytes[j], {(j == 4 * n - 1), b});
    end
  endtask

  initial begin
    logic [5:0] pm;
    logic [13:0] a;
    logic [15:0] cnt;
    logic [5:0] p_unused;
    int n_unused;
    bit seen;

    #1 reset_n = 1'b0;
    #2;
    chk_eq("rst_req_ready", req_ready, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_valid", udp_sink_valid, 0);
    chk_eq("rst_rd_en", ctrl_rd_en, 0);
    chk_eq("rst_length", udp_sink_length, 0);
    chk_eq("rst_src", udp_sink_src_port, 0);
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    #2 chk_eq("ready_before_clk", req_ready, 0);
    @(posedge clock);
    #1 chk_eq("ready_after_clk", req_ready, 1);

    run_req(6'b000100, 14'd5, 16'd2, 32'hC0A8_0102, 16'd5000);
    if (bytes.size() == 8) chk_eq("t1_last_only_8", bytes[6][8], 0);
    run_req(6'b000001, 14'h1234, 16'd1, 32'h0A00_0001, 16'd1234);
    if (bytes.size() == 4) begin
      chk_eq("known_b0", bytes[0], {1'b0, 8'h48});
      chk_eq("known_b1", bytes[1], {1'b0, 8'hD3});
      chk_eq("known_b2", bytes[2], {1'b0, 8'hF5});
      chk_eq("known_b3", bytes[3], {1'b1, 8'h6A});
    end
    rnd_ready = 1'b1;
    run_req(6'b100000, 14'd16383, 16'd3, 32'h1111_2222, 16'd7);
    run_req(6'b010000, 14'd100, 16'd1000, 32'h3333_4444, 16'd8);
    run_req(6'b000001, 14'd9, 16'd0, 32'h5, 16'd9);
    run_req(6'b000110, 14'd20, 16'd2, 32'h6, 16'd10);
    run_req(6'b000000, 14'd30, 16'd5, 32'h7, 16'd11);
    for (int t = 0; t < 10; t++) begin
      pm  = 6'($urandom_range(0, 63));
      a   = ($urandom_range(0, 3) == 0) ? 14'(16380 + $urandom_range(0, 3)) : 14'($urandom);
      cnt = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(200, 400)) : 16'($urandom_range(0, 12));
      rnd_ready = ($urandom_range(0, 1) == 1);
      run_req(pm, a, cnt, $urandom, 16'($urandom));
    end

    rnd_ready = 1'b0;
    set_expect(6'b000001, 16'd5, 32'hAAAA_5555, 16'd99, p_unused, n_unused);
    issue(6'b000001, 14'd100, 16'd5, 32'hAAAA_5555, 16'd99);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clock);
      seen = udp_sink_valid;
    end
    chk_eq("mid_send_reached", seen, 1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk_eq("arst_valid", udp_sink_valid, 0);
    chk_eq("arst_busy", busy, 0);
    chk_eq("arst_rd_en", ctrl_rd_en, 0);
    chk_eq("arst_last", udp_sink_last, 0);
    chk_eq("arst_req_ready", req_ready, 0);
    repeat (3) @(negedge clock);
    chk_eq("arst_no_done", done_cnt, 0);
    reset_n = 1'b1;
    run_req(6'b001000, 14'd16382, 16'd4, 32'hDEAD_BEEF, 16'd4242);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
